// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: serves mfc0/mtc0 from writeback, commits
// exceptions and eret, runs the Count/Compare timer and raises int_req.
module cp0_regfile #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
   parameter int unsigned HW_INT_W  = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                c0_we,
   input  logic [7:0]          c0_addr,
   input  logic [31:0]         c0_wdata,
   output logic [31:0]         c0_rdata,
   input  logic                wb_ex,
   input  logic                wb_bd,
   input  logic [4:0]          wb_exccode,
   input  logic [31:0]         wb_badvaddr,
   input  logic [31:0]         wb_pc,
   input  logic                wb_eret,
   input  logic [HW_INT_W-1:0] ext_int,
   output logic                int_req,
   output logic [31:0]         epc_out,
   output logic [31:0]         exc_target
);

   localparam int unsigned DATA_W    = 32;
   localparam int unsigned IP_W      = 8;
   localparam int unsigned EXCCODE_W = 5;

   // {rd, sel} encodings of the implemented registers (sel is always 0)
   localparam logic [7:0] ADDR_BADVADDR = 8'h40;
   localparam logic [7:0] ADDR_COUNT    = 8'h48;
   localparam logic [7:0] ADDR_COMPARE  = 8'h58;
   localparam logic [7:0] ADDR_STATUS   = 8'h60;
   localparam logic [7:0] ADDR_CAUSE    = 8'h68;
   localparam logic [7:0] ADDR_EPC      = 8'h70;

   localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'h04;
   localparam logic [EXCCODE_W-1:0] EXC_ADES = 5'h05;

   logic [DATA_W-1:0]    badvaddr_q, badvaddr_d;
   logic [DATA_W-1:0]    count_q,    count_d;
   logic [DATA_W-1:0]    compare_q,  compare_d;
   logic [DATA_W-1:0]    epc_q,      epc_d;
   logic                 tick_q,     tick_d;
   logic [IP_W-1:0]      im_q,       im_d;
   logic                 exl_q,      exl_d;
   logic                 ie_q,       ie_d;
   logic                 bd_q,       bd_d;
   logic                 ti_q,       ti_d;
   logic [IP_W-1:0]      ip_q,       ip_d;
   logic [EXCCODE_W-1:0] exccode_q,  exccode_d;

   logic sw_we;
   logic we_count;
   logic we_compare;
   logic we_status;
   logic we_cause;
   logic we_epc;
   logic addr_exc;

   // mtc0 is dropped entirely when an exception or eret commits in the same cycle
   always_comb begin
      sw_we      = c0_we & ~wb_ex & ~wb_eret;
      we_count   = sw_we & (c0_addr == ADDR_COUNT);
      we_compare = sw_we & (c0_addr == ADDR_COMPARE);
      we_status  = sw_we & (c0_addr == ADDR_STATUS);
      we_cause   = sw_we & (c0_addr == ADDR_CAUSE);
      we_epc     = sw_we & (c0_addr == ADDR_EPC);
      addr_exc   = (wb_exccode == EXC_ADEL) | (wb_exccode == EXC_ADES);
   end

   // Next-state for every CP0 register
   always_comb begin
      badvaddr_d = badvaddr_q;
      count_d    = count_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      tick_d     = tick_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_d       = ip_q;
      exccode_d  = exccode_q;

      // Count advances every other cycle; a software load restarts the phase
      if (we_count) begin
         count_d = c0_wdata;
         tick_d  = 1'b0;
      end else begin
         tick_d = ~tick_q;
         if (tick_q) begin
            count_d = count_q + DATA_W'(1);
         end
      end

      // Writing Compare acknowledges the timer, overriding a same-cycle match
      if (we_compare) begin
         compare_d = c0_wdata;
         ti_d      = 1'b0;
      end else if (count_q == compare_q) begin
         ti_d = 1'b1;
      end

      // Hardware interrupt lines are sampled every cycle; IP7 shares the timer
      ip_d[7]   = ext_int[5] | ti_q;
      ip_d[6:2] = ext_int[4:0];
      if (we_cause) begin
         ip_d[1:0] = c0_wdata[9:8];
      end

      if (wb_ex) begin
         exl_d     = 1'b1;
         exccode_d = wb_exccode;
         if (!exl_q) begin
            epc_d = wb_bd ? (wb_pc - DATA_W'(4)) : wb_pc;
            bd_d  = wb_bd;
         end
         if (addr_exc) begin
            badvaddr_d = wb_badvaddr;
         end
      end else if (wb_eret) begin
         exl_d = 1'b0;
      end else begin
         if (we_status) begin
            im_d  = c0_wdata[15:8];
            exl_d = c0_wdata[1];
            ie_d  = c0_wdata[0];
         end
         if (we_epc) begin
            epc_d = c0_wdata;
         end
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         tick_q     <= 1'b0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_q       <= '0;
         exccode_q  <= '0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         tick_q     <= tick_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_q       <= ip_d;
         exccode_q  <= exccode_d;
      end
   end

   // mfc0 read mux; unimplemented addresses and sel!=0 read zero
   always_comb begin
      c0_rdata = '0;
      unique case (c0_addr)
         ADDR_BADVADDR: c0_rdata = badvaddr_q;
         ADDR_COUNT:    c0_rdata = count_q;
         ADDR_COMPARE:  c0_rdata = compare_q;
         ADDR_STATUS:   c0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
         ADDR_CAUSE:    c0_rdata = {bd_q, ti_q, 14'b0, ip_q, 1'b0, exccode_q, 2'b0};
         ADDR_EPC:      c0_rdata = epc_q;
         default:       c0_rdata = '0;
      endcase
   end

   // Interrupt request and redirect vectors
   always_comb begin
      int_req    = ie_q & ~exl_q & (|(ip_q & im_q));
      epc_out    = epc_q;
      exc_target = EXC_ENTRY;
   end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: stimulus pushes expected values into a
// queue, a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_regfile;

   localparam logic [7:0] A_BADVADDR = 8'h40;
   localparam logic [7:0] A_COUNT    = 8'h48;
   localparam logic [7:0] A_COMPARE  = 8'h58;
   localparam logic [7:0] A_STATUS   = 8'h60;
   localparam logic [7:0] A_CAUSE    = 8'h68;
   localparam logic [7:0] A_EPC      = 8'h70;

   localparam int K_RDATA = 0;
   localparam int K_INT   = 1;
   localparam int K_EPC   = 2;
   localparam int K_EXC   = 3;

   logic        clk;
   logic        reset;
   logic        c0_we;
   logic [7:0]  c0_addr;
   logic [31:0] c0_wdata;
   logic [31:0] c0_rdata;
   logic        wb_ex;
   logic        wb_bd;
   logic [4:0]  wb_exccode;
   logic [31:0] wb_badvaddr;
   logic [31:0] wb_pc;
   logic        wb_eret;
   logic [5:0]  ext_int;
   logic        int_req;
   logic [31:0] epc_out;
   logic [31:0] exc_target;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];
   int          kind_q[$];
   string       name_q[$];

   cp0_regfile dut (
      .clk         (clk),
      .reset       (reset),
      .c0_we       (c0_we),
      .c0_addr     (c0_addr),
      .c0_wdata    (c0_wdata),
      .c0_rdata    (c0_rdata),
      .wb_ex       (wb_ex),
      .wb_bd       (wb_bd),
      .wb_exccode  (wb_exccode),
      .wb_badvaddr (wb_badvaddr),
      .wb_pc       (wb_pc),
      .wb_eret     (wb_eret),
      .ext_int     (ext_int),
      .int_req     (int_req),
      .epc_out     (epc_out),
      .exc_target  (exc_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: drain every expectation queued for this cycle
   always @(negedge clk) begin
      logic [31:0] e;
      logic [31:0] a;
      int          k;
      string       n;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         k = kind_q.pop_front();
         n = name_q.pop_front();
         case (k)
            K_RDATA: a = c0_rdata;
            K_INT:   a = {31'b0, int_req};
            K_EPC:   a = epc_out;
            default: a = exc_target;
         endcase
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
         end
      end
   end

   task automatic push(input int k, input logic [31:0] e, input string n);
      kind_q.push_back(k);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      c0_we   = 1'b0;
      wb_ex   = 1'b0;
      wb_eret = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      c0_we    = 1'b1;
      c0_addr  = a;
      c0_wdata = d;
      step();
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] e, input string n);
      c0_addr = a;
      push(K_RDATA, e, n);
   endtask

   task automatic exc(input logic bd, input logic [31:0] pc, input logic [4:0] code,
                      input logic [31:0] bva);
      wb_ex       = 1'b1;
      wb_bd       = bd;
      wb_pc       = pc;
      wb_exccode  = code;
      wb_badvaddr = bva;
      step();
   endtask

   initial begin
      reset = 1'b1; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
      wb_ex = 1'b0; wb_bd = 1'b0; wb_exccode = '0; wb_badvaddr = '0;
      wb_pc = '0; wb_eret = 1'b0; ext_int = '0;

      // Reset contents
      do_reset();
      rd(A_CAUSE, 32'h0, "rst_cause");
      push(K_INT, 32'h0, "rst_int");
      push(K_EPC, 32'h0, "rst_epc_out");
      push(K_EXC, 32'hBFC0_0380, "exc_target");
      step();
      rd(A_COUNT, 32'h0, "rst_count");            step();
      rd(A_STATUS, 32'h0040_0000, "rst_status");  step();
      rd(A_COMPARE, 32'h0, "rst_compare");        step();
      rd(A_BADVADDR, 32'h0, "rst_badvaddr");      step();
      rd(A_EPC, 32'h0, "rst_epc");                step();
      rd(8'h61, 32'h0, "status_sel1_zero");       step();
      wr(8'h61, 32'hFFFF_FFFF);
      rd(A_STATUS, 32'h0040_0000, "sel1_write_ignored"); step();
      wr(A_COMPARE, 32'hFFFF_0000);
      step();
      step();

      // Ordinary exception then eret
      exc(1'b0, 32'hBFC0_1000, 5'h0C, 32'h0000_DEAD);
      rd(A_EPC, 32'hBFC0_1000, "exc_epc");
      push(K_EPC, 32'hBFC0_1000, "exc_epc_out");
      step();
      rd(A_CAUSE, 32'h0000_0030, "exc_cause");     step();
      rd(A_STATUS, 32'h0040_0002, "exc_status");   step();
      rd(A_BADVADDR, 32'h0, "exc_badvaddr_kept");  step();
      wb_eret = 1'b1;
      step();
      rd(A_STATUS, 32'h0040_0000, "eret_status");
      push(K_EPC, 32'hBFC0_1000, "eret_epc_out");
      step();

      // Delay-slot AdEL, then nested exception with EXL set
      exc(1'b1, 32'hBFC0_2004, 5'h04, 32'h0000_0003);
      rd(A_EPC, 32'hBFC0_2000, "bd_epc");          step();
      rd(A_CAUSE, 32'h8000_0010, "bd_cause");      step();
      rd(A_BADVADDR, 32'h0000_0003, "adel_bva");   step();
      exc(1'b0, 32'hBFC0_3000, 5'h0C, 32'h0000_0077);
      rd(A_EPC, 32'hBFC0_2000, "nested_epc");
      push(K_EPC, 32'hBFC0_2000, "nested_epc_out");
      step();
      rd(A_CAUSE, 32'h8000_0030, "nested_cause");  step();
      rd(A_BADVADDR, 32'h0000_0003, "nested_bva"); step();

      // Timer interrupt
      do_reset();
      wr(A_STATUS, 32'h0000_8001);
      wr(A_COMPARE, 32'h0000_0005);
      wr(A_COUNT, 32'h0);
      rd(A_COUNT, 32'h0, "tmr_count0");
      push(K_INT, 32'h0, "tmr_int0");
      step();
      repeat (8) step();
      rd(A_COUNT, 32'h4, "tmr_count4");
      push(K_INT, 32'h0, "tmr_int_c4");
      step();
      rd(A_COUNT, 32'h5, "tmr_count5");            step();
      rd(A_CAUSE, 32'h4000_0000, "tmr_ti");
      push(K_INT, 32'h0, "tmr_int_ti");
      step();
      rd(A_CAUSE, 32'h4000_8000, "tmr_ip7");
      push(K_INT, 32'h1, "tmr_int_req");
      step();
      wr(A_COMPARE, 32'h0000_0100);
      rd(A_CAUSE, 32'h0000_8000, "tmr_ti_clr");
      push(K_INT, 32'h1, "tmr_int_lag");
      step();
      rd(A_CAUSE, 32'h0, "tmr_ip7_clr");
      push(K_INT, 32'h0, "tmr_int_clr");
      step();

      // Software and hardware interrupt lines
      do_reset();
      wr(A_COMPARE, 32'hFFFF_0000);
      wr(A_CAUSE, 32'hFFFF_FFFF);
      rd(A_CAUSE, 32'h0000_0300, "sw_cause");
      push(K_INT, 32'h0, "sw_int_ie0");
      step();
      wr(A_STATUS, 32'h0000_0101);
      rd(A_STATUS, 32'h0040_0101, "sw_status");
      push(K_INT, 32'h1, "sw_int_req");
      step();
      wr(A_STATUS, 32'h0000_0103);
      rd(A_STATUS, 32'h0040_0103, "exl_status");
      push(K_INT, 32'h0, "exl_masks_int");
      step();
      ext_int = 6'b00_0001;
      step();
      rd(A_CAUSE, 32'h0000_0700, "hw_ip2");
      ext_int = 6'b00_0000;
      step();
      rd(A_CAUSE, 32'h0000_0300, "hw_ip2_clr");    step();

      // Priority, Count load with pending increment, Count wrap
      do_reset();
      wr(A_COMPARE, 32'hFFFF_0000);
      c0_we = 1'b1; c0_addr = A_EPC; c0_wdata = 32'h0000_1234;
      exc(1'b0, 32'hBFC0_4000, 5'h08, 32'h0);
      rd(A_EPC, 32'hBFC0_4000, "prio_epc");
      push(K_EPC, 32'hBFC0_4000, "prio_epc_out");
      step();
      c0_we = 1'b1; c0_addr = A_STATUS; c0_wdata = 32'h0000_FF01; wb_eret = 1'b1;
      step();
      rd(A_STATUS, 32'h0040_0000, "prio_eret_drop"); step();
      wr(A_COUNT, 32'h0000_1000);
      rd(A_COUNT, 32'h0000_1000, "cnt_load");      step();
      rd(A_COUNT, 32'h0000_1000, "cnt_hold");      step();
      rd(A_COUNT, 32'h0000_1001, "cnt_inc");       step();
      wr(A_COUNT, 32'hFFFF_FFFF);
      rd(A_COUNT, 32'hFFFF_FFFF, "cnt_max");       step();
      step();
      rd(A_COUNT, 32'h0, "cnt_wrap");              step();

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d expected=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
